// File: rtl/seg_pwm_dimmer_pkg.sv
// Shared constants and helpers for the seven-segment PWM dimmer.
package seg_pwm_dimmer_pkg;

    localparam int DEF_MAX_LEVEL   = 15;
    localparam int DEF_STEP_CYC    = 1000;
    localparam int DEF_FADE_FRAMES = 8;

    // Active-low segments: all ones turns every segment off.
    localparam logic [63:0] SEG_BLANK = '1;

    function automatic int sat_level(input int level, input int max_level);
        return (level > max_level) ? max_level : level;
    endfunction

endpackage

// File: rtl/seg_pwm_dimmer_channel.sv
// One dimmer channel: latched target, current level, threshold compare, output register.
// Ramp logic is present only when SEG_PWM_DIMMER_FADE_EN is defined.
module pwm_channel
    import seg_pwm_dimmer_pkg::*;
#(
    parameter int SEG_W     = 8,
    parameter int DUTY_W    = 4,
    parameter int MAX_LEVEL = DEF_MAX_LEVEL,
    parameter int STEP_CYC  = DEF_STEP_CYC,
    parameter int THR_W     = 14
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              frame_start,
`ifdef SEG_PWM_DIMMER_FADE_EN
    input  logic              fade_step,
    output logic              busy,
`endif
    input  logic [DUTY_W-1:0] duty,
    input  logic [SEG_W-1:0]  seg_in,
    input  logic [THR_W-1:0]  cnt,
    output logic [SEG_W-1:0]  seg_out
);

    localparam logic [THR_W-1:0] STEP_T = THR_W'(STEP_CYC);

    logic [DUTY_W-1:0] sat_duty;
    logic [DUTY_W-1:0] cur_reg, cur_next;
    logic [THR_W-1:0]  thr;
    logic [SEG_W-1:0]  seg_out_reg;

    assign sat_duty = DUTY_W'(sat_level(int'(duty), MAX_LEVEL));

`ifdef SEG_PWM_DIMMER_FADE_EN
    logic [DUTY_W-1:0] tgt_reg, tgt_next;

    // Step toward the target being latched this frame so a reversal takes effect immediately.
    always_comb begin
        tgt_next = frame_start ? sat_duty : tgt_reg;
        cur_next = cur_reg;
        if (fade_step) begin
            if (cur_reg < tgt_next) begin
                cur_next = cur_reg + DUTY_W'(1);
            end else if (cur_reg > tgt_next) begin
                cur_next = cur_reg - DUTY_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tgt_reg <= '0;
        end else begin
            tgt_reg <= tgt_next;
        end
    end

    assign busy = (cur_reg != tgt_reg);
`else
    always_comb begin
        cur_next = frame_start ? sat_duty : cur_reg;
    end
`endif

    // Compare against the next level so a frame-start update shapes that frame's first output.
    assign thr = THR_W'(cur_next) * STEP_T;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_reg     <= '0;
            seg_out_reg <= SEG_BLANK[SEG_W-1:0];
        end else begin
            cur_reg     <= cur_next;
            seg_out_reg <= (en && (cnt < thr)) ? seg_in : SEG_BLANK[SEG_W-1:0];
        end
    end

    assign seg_out = seg_out_reg;

endmodule

// File: rtl/seg_pwm_dimmer.sv
// N-channel PWM dimmer for active-low seven-segment patterns.
// Define SEG_PWM_DIMMER_FADE_EN to compile in frame-divided brightness fading.
module seg_pwm_dimmer
    import seg_pwm_dimmer_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int SEG_W       = 8,
    parameter int DUTY_W      = 4,
    parameter int MAX_LEVEL   = DEF_MAX_LEVEL,
    parameter int STEP_CYC    = DEF_STEP_CYC,
    parameter int FADE_FRAMES = DEF_FADE_FRAMES
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [N_CH*DUTY_W-1:0]  duty,
    input  logic [N_CH*SEG_W-1:0]   seg_in,
    output logic [N_CH*SEG_W-1:0]   seg_out,
    output logic                    frame_tick,
    output logic                    fade_busy
);

    localparam int PERIOD = MAX_LEVEL * STEP_CYC;
    localparam int CNT_W  = $clog2(PERIOD);
    localparam int THR_W  = $clog2(PERIOD + 1);

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [THR_W-1:0] cnt_ext;
    logic             frame_start;
    logic             frame_tick_reg;

    assign frame_start = en && (cnt_reg == '0);
    assign cnt_ext     = THR_W'(cnt_reg);

    always_comb begin
        cnt_next = '0;
        if (en) begin
            cnt_next = (cnt_reg == CNT_W'(PERIOD - 1)) ? '0 : cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg        <= '0;
            frame_tick_reg <= 1'b0;
        end else begin
            cnt_reg        <= cnt_next;
            frame_tick_reg <= frame_start;
        end
    end

    assign frame_tick = frame_tick_reg;

`ifdef SEG_PWM_DIMMER_FADE_EN
    localparam int DIV_W = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;

    logic [DIV_W-1:0] div_reg;
    logic             fade_step;
    logic [N_CH-1:0]  ch_busy;
    logic             fade_busy_reg;

    assign fade_step = frame_start && (div_reg == DIV_W'(FADE_FRAMES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_reg       <= '0;
            fade_busy_reg <= 1'b0;
        end else begin
            if (!en) begin
                div_reg <= '0;
            end else if (frame_start) begin
                div_reg <= fade_step ? '0 : div_reg + DIV_W'(1);
            end
            fade_busy_reg <= |ch_busy;
        end
    end

    assign fade_busy = fade_busy_reg;
`else
    assign fade_busy = 1'b0;
`endif

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            pwm_channel #(
                .SEG_W     (SEG_W),
                .DUTY_W    (DUTY_W),
                .MAX_LEVEL (MAX_LEVEL),
                .STEP_CYC  (STEP_CYC),
                .THR_W     (THR_W)
            ) u_ch (
                .clk         (clk),
                .rst         (rst),
                .en          (en),
                .frame_start (frame_start),
`ifdef SEG_PWM_DIMMER_FADE_EN
                .fade_step   (fade_step),
                .busy        (ch_busy[gi]),
`endif
                .duty        (duty[gi*DUTY_W +: DUTY_W]),
                .seg_in      (seg_in[gi*SEG_W +: SEG_W]),
                .cnt         (cnt_ext),
                .seg_out     (seg_out[gi*SEG_W +: SEG_W])
            );
        end
    endgenerate

endmodule

// File: doc/seg_pwm_dimmer.md
# seg_pwm_dimmer

Multi-channel PWM brightness controller for the seven-segment display path. Each channel takes one active-low segment pattern and gates it on for a programmable fraction of a fixed PWM frame. The block sits between the digit/segment encoder and the display pins. It generalises the single-digit fixed-period dimmer to N channels with parametrised period, duty resolution, frame-aligned glitch-free duty updates and optional brightness fading.

## Interface
Parameters:
- N_CH, 4: number of independent display channels.
- SEG_W, 8: segment bits per channel.
- DUTY_W, 4: duty-level width.
- MAX_LEVEL, 15: full-brightness level; the frame is MAX_LEVEL slots long.
- STEP_CYC, 1000: clock cycles per duty slot.
- FADE_FRAMES, 8: frames per one-level fade step; used only with fading compiled in.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: reset; asynchronous, active-high.
- en, in, 1: dimmer enable.
- duty, in, N_CH*DUTY_W: target level per channel; channel i occupies bits [i*DUTY_W +: DUTY_W].
- seg_in, in, N_CH*SEG_W: active-low segment patterns, packed the same way as duty.
- seg_out, out, N_CH*SEG_W: gated patterns, registered.
- frame_tick, out, 1: one-cycle pulse on the first cycle of each frame.
- fade_busy, out, 1: high while any channel's current level differs from its latched target.

## Operation
- Frame length is PERIOD = MAX_LEVEL*STEP_CYC cycles. Frame counter cnt runs 0 to PERIOD-1, then wraps to 0. There is no extra terminal cycle.
- Counter width is $clog2(PERIOD). The compare threshold cur[i]*STEP_CYC is computed at width $clog2(PERIOD+1) with no truncation.
- Channel i is on when cnt < cur[i]*STEP_CYC. When on, seg_out[i] = seg_in[i]; otherwise seg_out[i] = all ones (blank).
- Level 0 is never on. Level MAX_LEVEL is on for the whole frame.
- A duty input above MAX_LEVEL saturates to MAX_LEVEL when latched.
- duty is sampled only when cnt == 0. The latched value is tgt[i]. Changes mid-frame never alter the current frame.
- Without fading: cur[i] <= tgt[i] at each frame start.
- With fading:
  - A frame-divider counter counts 0 to FADE_FRAMES-1 and advances once per frame.
  - On the frame where the divider wraps, each cur[i] moves one level toward tgt[i]: +1 when below, -1 when above, unchanged when equal.
  - A target that reverses mid-fade changes the ramp direction at the next step.
- en low:
  - cnt and the frame divider are forced to 0.
  - seg_out is blank and frame_tick is 0.
  - cur and tgt hold their values.
  - When en rises, a new frame starts with cnt == 0 on the first enabled cycle, and duty is latched on that cycle.

## Timing
- Reset values: cnt = 0, divider = 0, cur = 0, tgt = 0, seg_out = all ones, frame_tick = 0, fade_busy = 0.
- seg_out latency is one cycle. seg_out at cycle t+1 reflects seg_in and cnt at cycle t.
- frame_tick is registered and asserts in the cycle after cnt == 0 is sampled, aligned with the first seg_out of the frame.
- A duty value latched at cnt == 0 affects seg_out starting at that same frame's first output (without fading).
- fade_busy is registered from (cur != tgt) for any channel. Without fading it is constant 0.
- Reset asserted mid-frame takes effect immediately and asynchronously. After reset is released, the first frame begins with cnt == 0.

## Configuration
- SEG_PWM_DIMMER_FADE_EN:
  - Defined: the frame divider, per-channel ramp logic and a live fade_busy are compiled in.
  - Undefined: cur is loaded directly from tgt each frame, the divider is absent, and fade_busy is tied to 0.
  - The port list is identical in both builds.

## Structure
- Package seg_pwm_dimmer_pkg holds:
  - default constants: DEF_MAX_LEVEL = 15, DEF_STEP_CYC = 1000, DEF_FADE_FRAMES = 8;
  - the blank pattern SEG_BLANK (all ones);
  - function sat_level(), which clamps a duty value to MAX_LEVEL.
- One sub-module, pwm_channel, is instantiated N_CH times. Each instance holds:
  - tgt, cur and the ramp step;
  - the threshold compare and the seg_out register.
- The top level owns cnt, the frame divider, frame_tick and the fade_busy reduction.

## Test plan
- Use STEP_CYC = 4 and MAX_LEVEL = 15, so PERIOD = 60. Set duty = 0, 1, 8 and 15 on channels 0 to 3 with seg_in = 8'h00. Required on-cycles per frame: 0, 4, 32, 60. frame_tick pulses every 60 cycles.
- Change duty on channel 2 from 8 to 3 at cnt = 10. The current frame still shows 32 on-cycles, and the next frame shows 12.
- Apply duty = 4'hF with MAX_LEVEL = 10. The channel saturates and is on for the full frame.
- Hold en low for 100 cycles mid-frame, then raise it. seg_out is all ones throughout. The first frame_tick arrives 1 cycle after en rises, and the frame that follows has the full length.
- Build with SEG_PWM_DIMMER_FADE_EN and FADE_FRAMES = 2, then step duty from 0 to 3. cur reaches 1, 2 and 3 after 2, 4 and 6 frames. fade_busy deasserts after the sixth frame. Reversing to 0 at level 2 ramps back down.
- Assert rst at cnt = 37. seg_out goes to all ones and cur to 0 immediately. After release, counting restarts from 0.
